line_mem_responder: RTL and testbench
=====================================

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning edges from request acceptance to ACK; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of the number of 128-bit lines stored.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port wb_cyc  input  1  bus cycle active from the initiator.
REQ-006 SHALL have port wb_stb  input  1  request strobe.
REQ-007 SHALL have port wb_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port wb_sel  input  16  byte enables for writes; bit i covers data byte i.
REQ-009 SHALL have port wb_adr  input  28  line address (byte address bits 31:4).
REQ-010 SHALL have port wb_dat_m  input  128  write data from the initiator.
REQ-011 SHALL have port wb_dat_s  output  128  read data to the initiator.
REQ-012 SHALL have port wb_ack  output  1  one-cycle completion pulse.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, WAIT and ACK.
REQ-015 IDLE SHALL accept a request on any edge where wb_cyc=1 and wb_stb=1.
REQ-016 On acceptance, the block SHALL capture wb_we, wb_sel, wb_dat_m and the index, where index = wb_adr[DEPTH_LOG2-1:0].
REQ-017 Upper address bits SHALL be ignored, so addresses alias modulo 2^DEPTH_LOG2 lines.
REQ-018 On acceptance with LATENCY=1, the FSM SHALL go directly to ACK.
REQ-019 On acceptance with LATENCY>1, the FSM SHALL go to WAIT and load the counter with LATENCY-2.
REQ-020 WAIT SHALL decrement the counter on each edge and go to ACK on the edge where the counter equals 0.
REQ-021 wb_ack SHALL be high exactly during the cycle that begins LATENCY edges after the acceptance edge.
REQ-022 ACK SHALL last one cycle, then return to IDLE unconditionally.
REQ-023 No request SHALL be accepted on the edge that leaves ACK; back-to-back requests therefore see at least one IDLE cycle between ACKs.
REQ-024 On a write, the edge entering ACK SHALL update each byte i of line[index] to wb_dat_m byte i where sel[i]=1; bytes with sel[i]=0 SHALL be unchanged.
REQ-025 On a read, the edge entering ACK SHALL load the output register with line[index].
REQ-026 wb_dat_s SHALL equal the output register during ACK and 128'h0 in every other cycle, including write ACKs.
REQ-027 Read data SHALL reflect all writes whose ACK occurred earlier.
REQ-028 Abort: if wb_cyc=0 on any edge while in WAIT, the FSM SHALL return to IDLE with no ACK and no memory update.
REQ-029 wb_stb dropping while wb_cyc stays 1 SHALL NOT abort a request.
REQ-030 Captured values SHALL be used for the whole transaction; changes to wb_adr, wb_dat_m, wb_sel or wb_we after acceptance SHALL be ignored.
REQ-031 wb_sel=16'h0000 on a write SHALL complete with ACK and leave memory unchanged.
REQ-032 busy SHALL be high in WAIT and ACK and low in IDLE.

Reset
REQ-033 While rst_n=0, the state SHALL be IDLE, wb_ack=0, wb_dat_s=0, busy=0, the counter 0 and all lines 128'h0.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction immediately with no memory update, and no ACK SHALL follow reset release.
REQ-035 The first request SHALL be acceptable on the first rising edge after rst_n rises.

Verification
REQ-036 Scenario 1: after reset, read adr 28'h0000003 with LATENCY=4 -> wb_ack high exactly 4 edges after acceptance for one cycle, wb_dat_s=128'h0, busy high for 4 cycles.
REQ-037 Scenario 2: write adr 5, sel 16'hFFFF, data 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, then read adr 5 -> read returns that value; wb_dat_s=0 during the write ACK.
REQ-038 Scenario 3: full-line write of all-ones to adr 2, then write sel 16'h000F data 0 to adr 2, then read -> returns 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000.
REQ-039 Scenario 4: write 128'hAA..AA to adr 28'h0000011 with DEPTH_LOG2=4, then read adr 1 -> returns 128'hAA..AA (alias).
REQ-040 Scenario 5: start a write to adr 7, drop wb_cyc two cycles after acceptance -> no ACK, FSM IDLE next cycle, and a later read of adr 7 returns 0.
REQ-041 Scenario 6: assert rst_n=0 during WAIT of a write to adr 9, release, then read adr 9 -> no stray ACK, read returns 0; repeat scenario 1 with LATENCY=1 -> ACK in the cycle immediately after acceptance.

Source files
------------

// File: rtl/line_mem_responder.sv
// Wishbone-style slave backed by a small array of 128-bit lines. Each request
// completes with a one-cycle wb_ack a fixed LATENCY edges after it is accepted.
module line_mem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wb_cyc,
  input  logic         wb_stb,
  input  logic         wb_we,
  input  logic [15:0]  wb_sel,
  input  logic [27:0]  wb_adr,
  input  logic [127:0] wb_dat_m,
  output logic [127:0] wb_dat_s,
  output logic         wb_ack,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Handshake: a request is taken on any edge where the FSM is IDLE and
  // wb_cyc & wb_stb are both high. It completes with wb_ack high for exactly
  // one cycle; dropping wb_cyc while waiting cancels it, dropping wb_stb does not.

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    enter_ack;
  logic                    accept;

  logic                    cap_we;
  logic [15:0]             cap_sel;
  logic [127:0]            cap_dat;
  logic [DEPTH_LOG2-1:0]   cap_idx;

  logic                    op_we;
  logic [15:0]             op_sel;
  logic [127:0]            op_dat;
  logic [DEPTH_LOG2-1:0]   op_idx;

  logic [DEPTH-1:0][127:0] lines;
  logic [127:0]            rdata_q;

  // Only the index bits address the store; upper line-address bits alias.
  logic                    unused_adr_hi;
  assign unused_adr_hi = ^wb_adr[27:DEPTH_LOG2];

  assign accept = (state_q == IDLE) && wb_cyc && wb_stb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enter_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d   = ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        // Cancellation wins over completion when both coincide.
        if (!wb_cyc) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d   = ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_we  <= 1'b0;
      cap_sel <= 16'h0;
      cap_dat <= 128'h0;
      cap_idx <= '0;
    end else if (accept) begin
      cap_we  <= wb_we;
      cap_sel <= wb_sel;
      cap_dat <= wb_dat_m;
      cap_idx <= wb_adr[DEPTH_LOG2-1:0];
    end
  end

  // With a single-edge latency the store is touched on the acceptance edge
  // itself, before the capture registers hold anything.
  always_comb begin
    op_we  = cap_we;
    op_sel = cap_sel;
    op_dat = cap_dat;
    op_idx = cap_idx;
    if (state_q == IDLE) begin
      op_we  = wb_we;
      op_sel = wb_sel;
      op_dat = wb_dat_m;
      op_idx = wb_adr[DEPTH_LOG2-1:0];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : gen_line
    logic [127:0] line_q;
    logic         line_we;

    assign line_we = enter_ack && op_we && (op_idx == DEPTH_LOG2'(g));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        line_q <= 128'h0;
      end else if (line_we) begin
        for (int b = 0; b < 16; b++) begin
          if (op_sel[b]) line_q[b*8 +: 8] <= op_dat[b*8 +: 8];
        end
      end
    end

    assign lines[g] = line_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 128'h0;
    end else if (enter_ack) begin
      rdata_q <= op_we ? 128'h0 : lines[op_idx];
    end
  end

  assign wb_ack    = (state_q == ACK);
  assign busy      = (state_q != IDLE);
  assign wb_dat_s  = wb_ack ? rdata_q : 128'h0;
  assign dbg_state = state_q;

  a_ack_single : assert property (@(posedge clk) disable iff (!rst_n)
    wb_ack |=> !wb_ack);

  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == WAIT) |-> (cnt_q <= CNT_LOAD));

  a_rd_quiet : assert property (@(posedge clk) disable iff (!rst_n)
    !wb_ack |-> (wb_dat_s == 128'h0));

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: two instances (LATENCY 4 and 1) with a table
// of directed transactions, corner sequences and randomized traffic.
module tb_line_mem_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cyc  [2];
  logic         stb  [2];
  logic         we   [2];
  logic [15:0]  sel  [2];
  logic [27:0]  adr  [2];
  logic [127:0] dm   [2];
  logic [127:0] ds   [2];
  logic         ack  [2];
  logic         busy [2];
  logic [1:0]   dbg  [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] model [2][16];
  logic [127:0] exp_q [$];

  typedef struct {
    bit           we;
    logic [27:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat;
    logic [127:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  localparam logic [127:0] PAT_D  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] PAT_AA = {16{8'hAA}};

  // clock / reset
  always #5 clk = ~clk;

  line_mem_responder #(.LATENCY(4), .DEPTH_LOG2(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we[0]),
    .wb_sel(sel[0]), .wb_adr(adr[0]), .wb_dat_m(dm[0]), .wb_dat_s(ds[0]),
    .wb_ack(ack[0]), .busy(busy[0]), .dbg_state(dbg[0])
  );

  line_mem_responder #(.LATENCY(1), .DEPTH_LOG2(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we[1]),
    .wb_sel(sel[1]), .wb_adr(adr[1]), .wb_dat_m(dm[1]), .wb_dat_s(ds[1]),
    .wb_ack(ack[1]), .busy(busy[1]), .dbg_state(dbg[1])
  );

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // Reference store: line index is the address modulo 16, byte-masked merge.
  function automatic void model_write(input int d, input logic [27:0] a,
                                      input logic [15:0] s, input logic [127:0] v);
    int idx;
    idx = int'(a % 28'd16);
    for (int b = 0; b < 16; b++)
      if (s[b]) model[d][idx][b*8 +: 8] = v[b*8 +: 8];
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) model[d][i] = 128'h0;
  endfunction

  // driver: one transaction, checking ack/busy/data on every cycle until idle
  task automatic do_txn(input int d, input bit w, input logic [27:0] a,
                        input logic [15:0] s, input logic [127:0] v,
                        input logic [127:0] exp_rd, input int abort_at);
    int lat;
    bit aborted;
    logic [127:0] exp_dat;
    lat = lat_of(d);
    aborted = 1'b0;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dm[d] = v;
    @(posedge clk); #1;
    // Request taken; wiggle everything the slave must have captured.
    stb[d] = 1'b0; we[d] = ~w; adr[d] = 28'($urandom);
    sel[d] = 16'($urandom); dm[d] = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      exp_dat = (k == lat && !w) ? exp_rd : 128'h0;
      chk($sformatf("ack d%0d k%0d", d, k), 128'(ack[d]), 128'(k == lat));
      chk($sformatf("busy d%0d k%0d", d, k), 128'(busy[d]), 128'd1);
      chk($sformatf("dat d%0d k%0d", d, k), ds[d], exp_dat);
      if (k == abort_at) begin
        cyc[d] = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    cyc[d] = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("idle ack d%0d ab%0d", d, aborted), 128'(ack[d]), 128'd0);
    chk($sformatf("idle busy d%0d ab%0d", d, aborted), 128'(busy[d]), 128'd0);
    chk($sformatf("idle dat d%0d", d), ds[d], 128'h0);
  endtask

  initial begin
    int d;
    bit w;
    logic [27:0] a;
    logic [15:0] s;
    logic [127:0] v;
    logic [127:0] e;
    int ab;
    int lat;
    int n_gap;

    vecs[0]  = '{we: 1'b0, adr: 28'h0000003, sel: 16'h0000, dat: 128'h0, exp_rd: 128'h0};
    vecs[1]  = '{we: 1'b1, adr: 28'h0000005, sel: 16'hFFFF, dat: PAT_D, exp_rd: 128'h0};
    vecs[2]  = '{we: 1'b0, adr: 28'h0000005, sel: 16'h0000, dat: 128'h0, exp_rd: PAT_D};
    vecs[3]  = '{we: 1'b1, adr: 28'h0000002, sel: 16'hFFFF, dat: {128{1'b1}}, exp_rd: 128'h0};
    vecs[4]  = '{we: 1'b1, adr: 28'h0000002, sel: 16'h000F, dat: 128'h0, exp_rd: 128'h0};
    vecs[5]  = '{we: 1'b0, adr: 28'h0000002, sel: 16'h0000, dat: 128'h0,
                 exp_rd: 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000};
    vecs[6]  = '{we: 1'b1, adr: 28'h0000011, sel: 16'hFFFF, dat: PAT_AA, exp_rd: 128'h0};
    vecs[7]  = '{we: 1'b0, adr: 28'h0000001, sel: 16'h0000, dat: 128'h0, exp_rd: PAT_AA};
    vecs[8]  = '{we: 1'b1, adr: 28'h0000001, sel: 16'h0000, dat: {16{8'h55}}, exp_rd: 128'h0};
    vecs[9]  = '{we: 1'b0, adr: 28'h0000001, sel: 16'h0000, dat: 128'h0, exp_rd: PAT_AA};
    vecs[10] = '{we: 1'b0, adr: 28'hFFFFFF5, sel: 16'h0000, dat: 128'h0, exp_rd: PAT_D};

    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; sel[i] = 16'h0; adr[i] = 28'h0; dm[i] = 128'h0;
    end
    model_clear();

    // Reset values, observed with the bus active to show it is ignored.
    cyc[0] = 1'b1; stb[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst ack d%0d", i), 128'(ack[i]), 128'd0);
      chk($sformatf("rst busy d%0d", i), 128'(busy[i]), 128'd0);
      chk($sformatf("rst dat d%0d", i), ds[i], 128'h0);
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Read right after reset release, then the single-edge latency variant.
    do_txn(0, 1'b0, 28'h0000003, 16'h0, 128'h0, 128'h0, 0);
    do_txn(1, 1'b0, 28'h0000003, 16'h0, 128'h0, 128'h0, 0);

    // Directed table on the LATENCY=4 instance.
    for (int i = 0; i < 11; i++) begin
      do_txn(0, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].exp_rd, 0);
      if (vecs[i].we) model_write(0, vecs[i].adr, vecs[i].sel, vecs[i].dat);
    end

    // Cancelled write: wb_cyc drops two cycles after acceptance.
    do_txn(0, 1'b1, 28'h0000007, 16'hFFFF, {4{32'hDEAD_BEEF}}, 128'h0, 2);
    do_txn(0, 1'b0, 28'h0000007, 16'h0, 128'h0, 128'h0, 0);

    // Strobe held continuously: an idle cycle must separate consecutive acks.
    for (int dd = 0; dd < 2; dd++) begin
      lat = lat_of(dd);
      e = model[dd][2];
      cyc[dd] = 1'b1; stb[dd] = 1'b1; we[dd] = 1'b0; adr[dd] = 28'h0000002;
      for (int k = 1; k <= 2 * (lat + 1); k++) begin
        @(posedge clk); #1;
        chk($sformatf("b2b ack d%0d k%0d", dd, k), 128'(ack[dd]), 128'((k % (lat + 1)) == lat));
        chk($sformatf("b2b busy d%0d k%0d", dd, k), 128'(busy[dd]), 128'((k % (lat + 1)) != 0));
        chk($sformatf("b2b dat d%0d k%0d", dd, k), ds[dd], ((k % (lat + 1)) == lat) ? e : 128'h0);
      end
      cyc[dd] = 1'b0; stb[dd] = 1'b0;
      @(posedge clk); #1;
    end

    // Reset in the middle of a write's wait phase.
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 28'h0000009;
    sel[0] = 16'hFFFF; dm[0] = {4{32'h1234_5678}};
    @(posedge clk); #1;
    stb[0] = 1'b0;
    @(posedge clk); #1;
    chk("pre-rst busy", 128'(busy[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst busy", 128'(busy[0]), 128'd0);
    chk("mid-rst ack", 128'(ack[0]), 128'd0);
    chk("mid-rst dat", ds[0], 128'h0);
    cyc[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post-rst ack k%0d", k), 128'(ack[0]), 128'd0);
    end
    do_txn(0, 1'b0, 28'h0000009, 16'h0, 128'h0, 128'h0, 0);
    do_txn(0, 1'b0, 28'h0000005, 16'h0, 128'h0, 128'h0, 0);

    // Randomized traffic against the reference store.
    for (int i = 0; i < 120; i++) begin
      d = $urandom_range(0, 1);
      w = 1'($urandom_range(0, 1));
      a = 28'($urandom);
      case ($urandom_range(0, 5))
        0:       s = 16'h0000;
        1:       s = 16'hFFFF;
        default: s = 16'($urandom);
      endcase
      v = {$urandom, $urandom, $urandom, $urandom};
      ab = (d == 0 && w && $urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      exp_q.push_back(w ? 128'h0 : model[d][int'(a % 28'd16)]);
      do_txn(d, w, a, s, v, exp_q.pop_front(), ab);
      if (w && ab == 0) model_write(d, a, s, v);
      n_gap = $urandom_range(0, 2);
      repeat (n_gap) begin @(posedge clk); #1; end
    end

    // Final sweep reading every line of both instances.
    for (int dd = 0; dd < 2; dd++)
      for (int i = 0; i < 16; i++)
        do_txn(dd, 1'b0, 28'(i + 16 * dd), 16'h0, 128'h0, model[dd][i], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
